// File: rtl/systolic_pkg.sv
// Shared types and lane-delay helper for the systolic skewer and its bench.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_e;

    // Skew: lane i waits i+1 cycles. Deskew mirrors it so lane 0 is slowest.
    function automatic int lane_delay(input int i, input int n, input int deskew);
        return (deskew != 0) ? (n - i) : (i + 1);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth {valid, data} shift register for one skewer lane; zeroes data on bubbles.
module skew_delay_line #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data
);

    logic [DEPTH-1:0]                vld_pipe;
    logic [DEPTH-1:0][DATA_SIZE-1:0] dat_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (shift) begin
            vld_pipe[0] <= in_valid;
            dat_pipe[0] <= in_valid ? in_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_skewer.sv
// Streaming row/column skewer (or deskewer) with stall, tail drain and done pulse.
// Optional perf counters behind SYSTOLIC_SKEWER_PERF_EN.
module systolic_skewer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_SIZE   = 32,
    parameter int DESKEW      = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data,
    input  logic                                  stall,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_skewed,
    output logic [MATRIX_SIZE-1:0]                lane_valid,
    output logic                                  busy,
    output logic                                  done
`ifdef SYSTOLIC_SKEWER_PERF_EN
    ,
    output logic [31:0]                           perf_beats,
    output logic [31:0]                           perf_stalls
`endif
);

    localparam int              CW         = $clog2(MATRIX_SIZE + 1);
    localparam logic [CW-1:0]   DRAIN_INIT = CW'(MATRIX_SIZE - 1);

    skew_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_d;
    logic          advance, accept;

    assign advance  = !stall;
    assign in_ready = !stall && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        skew_delay_line #(
            .DATA_SIZE (DATA_SIZE),
            .DEPTH     (lane_delay(i, MATRIX_SIZE, DESKEW))
        ) u_dl (
            .clk       (clk),
            .reset     (reset),
            .shift     (advance),
            .in_valid  (accept),
            .in_data   (data[i]),
            .out_valid (lane_valid[i]),
            .out_data  (data_skewed[i])
        );
    end

    // done is raised on the edge the counter reaches zero, so it lines up with the
    // slowest lane's output; the state leaves DRAIN one advance later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_INIT;
                        done_d  = (DRAIN_INIT == '0);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (advance) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        done_d = (cnt_q == CW'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done    <= 1'b0;
        end else if (advance) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
        end
    end

`ifdef SYSTOLIC_SKEWER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept && (perf_beats != '1))
                perf_beats <= perf_beats + 32'd1;
            if (stall && busy && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skewer.sv
// Directed bench: skew, deskew, bubbles, stall, mid-stream reset and N=1 on three instances.
module tb_systolic_skewer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared stimulus for the N=4 skew (0) and deskew (1) instances
    logic                iv, last, stall;
    logic [3:0][DW-1:0]  dat;
    logic                rdy0, rdy1, busy0, busy1, done0, done1;
    logic [3:0][DW-1:0]  q0, q1;
    logic [3:0]          lv0, lv1;

    // N=1 instance
    logic                iv2, last2, stall2, rdy2, busy2, done2;
    logic [0:0][DW-1:0]  dat2, q2;
    logic [0:0]          lv2;

`ifdef SYSTOLIC_SKEWER_PERF_EN
    logic [31:0] pb0, ps0, pb1, ps1, pb2, ps2;
`endif

    systolic_skewer #(.MATRIX_SIZE(4), .DATA_SIZE(DW), .DESKEW(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(rdy0), .in_last(last),
        .data(dat), .stall(stall), .data_skewed(q0), .lane_valid(lv0),
        .busy(busy0), .done(done0)
`ifdef SYSTOLIC_SKEWER_PERF_EN
        , .perf_beats(pb0), .perf_stalls(ps0)
`endif
    );

    systolic_skewer #(.MATRIX_SIZE(4), .DATA_SIZE(DW), .DESKEW(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(rdy1), .in_last(last),
        .data(dat), .stall(stall), .data_skewed(q1), .lane_valid(lv1),
        .busy(busy1), .done(done1)
`ifdef SYSTOLIC_SKEWER_PERF_EN
        , .perf_beats(pb1), .perf_stalls(ps1)
`endif
    );

    systolic_skewer #(.MATRIX_SIZE(1), .DATA_SIZE(DW), .DESKEW(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(rdy2), .in_last(last2),
        .data(dat2), .stall(stall2), .data_skewed(q2), .lane_valid(lv2),
        .busy(busy2), .done(done2)
`ifdef SYSTOLIC_SKEWER_PERF_EN
        , .perf_beats(pb2), .perf_stalls(ps2)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0][DW-1:0] V1, V2, A1, A2, e_q0, e_q1;
    logic [3:0]         e_v0, e_v1;
    int                 t;

    initial begin
        V1 = {32'd4, 32'd3, 32'd2, 32'd1};
        V2 = {32'd8, 32'd7, 32'd6, 32'd5};
        A1 = {4{32'd1}};
        A2 = {4{32'd2}};
        reset = 1'b1; iv = 0; last = 0; stall = 0; dat = '0;
        iv2 = 0; last2 = 0; stall2 = 0; dat2 = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_q0", q0, '0);
        chk("rst_lv0", lv0, '0);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_rdy2", rdy2, 1);

        // stall with valid in IDLE: nothing accepted
        stall = 1; iv = 1; dat = V1;
        #1;
        chk("stall_rdy", rdy0, 0);
        tick();
        stall = 0; iv = 0;
        #1;
        chk("stall_noacc_busy", busy0, 0);
        chk("stall_noacc_lv", lv0, '0);

        // N=1 single vector with last
        iv2 = 1; last2 = 1; dat2[0] = 32'd9;
        #1;
        chk("n1_rdy", rdy2, 1);
        tick();
        iv2 = 0; last2 = 0;
        #1;
        chk("n1_q", q2, 32'd9);
        chk("n1_lv", lv2, 1);
        chk("n1_done", done2, 1);
        tick();
        chk("n1_done_off", done2, 0);
        chk("n1_busy_off", busy2, 0);
`ifdef SYSTOLIC_SKEWER_PERF_EN
        chk("n1_perf_beats", pb2, 1);
        chk("n1_perf_stalls", ps2, 0);
`endif

        // two vectors, skew and deskew
        for (int c = 0; c <= 6; c++) begin
            iv = (c < 2); dat = (c == 0) ? V1 : V2; last = (c == 1);
            #1;
            e_q0 = '0; e_v0 = '0; e_q1 = '0; e_v1 = '0;
            for (int i = 0; i < 4; i++) begin
                if (c == i + 1) begin e_v0[i] = 1; e_q0[i] = V1[i]; end
                if (c == i + 2) begin e_v0[i] = 1; e_q0[i] = V2[i]; end
                if (c == 4 - i) begin e_v1[i] = 1; e_q1[i] = V1[i]; end
                if (c == 5 - i) begin e_v1[i] = 1; e_q1[i] = V2[i]; end
            end
            chk($sformatf("skew_q c%0d", c), q0, e_q0);
            chk($sformatf("skew_lv c%0d", c), lv0, e_v0);
            chk($sformatf("deskew_q c%0d", c), q1, e_q1);
            chk($sformatf("deskew_lv c%0d", c), lv1, e_v1);
            chk($sformatf("skew_done c%0d", c), done0, (c == 5));
            chk($sformatf("deskew_done c%0d", c), done1, (c == 5));
            chk($sformatf("skew_busy c%0d", c), busy0, (c >= 1 && c <= 5));
            chk($sformatf("deskew_busy c%0d", c), busy1, (c >= 1 && c <= 5));
            chk($sformatf("skew_rdy c%0d", c), rdy0, !(c >= 2 && c <= 5));
            chk($sformatf("deskew_rdy c%0d", c), rdy1, !(c >= 2 && c <= 5));
            tick();
        end
`ifdef SYSTOLIC_SKEWER_PERF_EN
        chk("perf_beats0", pb0, 2);
        chk("perf_beats1", pb1, 2);
`endif

        // bubbles between two vectors
        for (int c = 0; c <= 8; c++) begin
            iv = (c == 0 || c == 3); dat = (c == 0) ? A1 : A2; last = (c == 3);
            #1;
            if (c >= 3 && c <= 6) begin
                chk($sformatf("bub_lv2 c%0d", c), lv0[2], (c == 3 || c == 6));
                chk($sformatf("bub_q2 c%0d", c), q0[2], (c == 3) ? 32'd1 : (c == 6) ? 32'd2 : 32'd0);
            end
            chk($sformatf("bub_done c%0d", c), done0, (c == 7));
            tick();
        end

        // single vector, 3-cycle stall during DRAIN
        for (int c = 0; c <= 8; c++) begin
            iv = (c == 0); dat = V1; last = (c == 0);
            stall = (c >= 2 && c <= 4);
            #1;
            t = (c <= 2) ? c : (c <= 5) ? 2 : c - 3;
            e_q0 = '0; e_v0 = '0;
            for (int i = 0; i < 4; i++)
                if (t == i + 1) begin e_v0[i] = 1; e_q0[i] = V1[i]; end
            chk($sformatf("stl_q c%0d", c), q0, e_q0);
            chk($sformatf("stl_lv c%0d", c), lv0, e_v0);
            chk($sformatf("stl_done c%0d", c), done0, (c == 7));
            chk($sformatf("stl_done1 c%0d", c), done1, (c == 7));
            chk($sformatf("stl_rdy c%0d", c), rdy0, (c == 0 || c == 8));
            tick();
        end
        stall = 0;
`ifdef SYSTOLIC_SKEWER_PERF_EN
        chk("perf_stalls0", ps0, 3);
        chk("perf_stalls1", ps1, 3);
`endif

        // reset while streaming
        for (int c = 0; c <= 8; c++) begin
            iv = (c < 2); dat = (c == 0) ? V1 : V2; last = 0;
            reset = (c == 2);
            #1;
            chk($sformatf("rmid_done c%0d", c), done0, 0);
            if (c == 1 || c == 2) chk($sformatf("rmid_busy_pre c%0d", c), busy0, 1);
            if (c >= 3) begin
                chk($sformatf("rmid_lv c%0d", c), lv0, '0);
                chk($sformatf("rmid_q c%0d", c), q0, '0);
                chk($sformatf("rmid_busy c%0d", c), busy0, 0);
                chk($sformatf("rmid_lv1 c%0d", c), lv1, '0);
            end
            tick();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
